// File: rtl/lsu_ctrl_if.sv
// Core-side and memory-side bus bundle for the load/store controller.
// The slave modport is the controller's view; master is the core+memory side.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
);
    // core request
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [2:0]        i_req_funct3;
    logic [ADDR_W-1:0] i_req_addr;
    logic [31:0]       i_req_wdata;
    // core response
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [31:0]       o_rsp_rdata;
    logic              o_rsp_trap;
    logic [1:0]        o_rsp_cause;
    // memory request / read return
    logic              o_mem_valid;
    logic              i_mem_ready;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_ren;
    logic              o_mem_wen;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_mask;
    logic              i_mem_rvalid;
    logic [31:0]       i_mem_rdata;
    // status
    logic              o_busy;

    modport slave (
        input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        input  i_rsp_ready, i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap, o_rsp_cause,
        output o_mem_valid, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
        output o_mem_mask, o_busy
    );

    modport master (
        output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        output i_rsp_ready, i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap, o_rsp_cause,
        input  o_mem_valid, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
        input  o_mem_mask, o_busy
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding RV32 load/store controller: legality check, byte-lane
// mask/data alignment, load extension and an ISSUE+WAIT timeout.
module lsu_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    lsu_ctrl_if.slave bus
);
    localparam int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // timeout fires in the cycle whose increment would make the count TIMEOUT
    localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              trap_q, trap_d;
    logic [1:0]        cause_q, cause_d;

    logic [1:0]  off;
    logic [4:0]  sh;
    logic [1:0]  in_off;
    logic        in_illegal, in_misal, timeout_hit;
    logic        st_issue, st_resp;
    logic [3:0]  mask;
    logic [31:0] wdata_al, rshift, ld_ext;

    assign off         = addr_q[1:0];
    assign sh          = {off, 3'b000};
    assign in_off      = bus.i_req_addr[1:0];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
    assign st_issue    = (state_q == ISSUE);
    assign st_resp     = (state_q == RESP);

    // legality of the request being offered (illegal funct3 outranks misalignment)
    always_comb begin
        in_illegal = bus.i_req_we ? (bus.i_req_funct3 >= 3'd3)
                                  : (bus.i_req_funct3 == 3'd3 || bus.i_req_funct3 >= 3'd6);
        in_misal   = (bus.i_req_funct3[1:0] == 2'b01 && in_off[0]) ||
                     (bus.i_req_funct3[1:0] == 2'b10 && in_off != 2'b00);
    end

    // byte-lane mask, store data alignment and load data extension
    always_comb begin
        mask     = 4'b1111;
        wdata_al = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                mask     = 4'b0001 << off;
                wdata_al = {24'b0, wdata_q[7:0]} << sh;
            end
            2'b01: begin
                mask     = 4'b0011 << off;
                wdata_al = {16'b0, wdata_q[15:0]} << sh;
            end
            default: ;
        endcase
        rshift = bus.i_mem_rdata >> sh;
        case (f3_q)
            3'd0:    ld_ext = {{24{rshift[7]}}, rshift[7:0]};
            3'd1:    ld_ext = {{16{rshift[15]}}, rshift[15:0]};
            3'd4:    ld_ext = {24'b0, rshift[7:0]};
            3'd5:    ld_ext = {16'b0, rshift[15:0]};
            default: ld_ext = rshift;
        endcase
    end

    // next-state and response capture
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: if (bus.i_req_valid) begin
                we_d    = bus.i_req_we;
                f3_d    = bus.i_req_funct3;
                addr_d  = bus.i_req_addr;
                wdata_d = bus.i_req_wdata;
                rdata_d = '0;
                trap_d  = 1'b0;
                cause_d = 2'b00;
                cnt_d   = '0;
                if (in_illegal) begin
                    trap_d  = 1'b1;
                    cause_d = 2'b11;
                    state_d = RESP;
                end else if (in_misal) begin
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.i_mem_ready) begin
                    state_d = we_q ? RESP : WAIT;
                end else if (timeout_hit) begin
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                    state_d = RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.i_mem_rvalid) begin
                    rdata_d = ld_ext;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                    state_d = RESP;
                end
            end
            RESP: if (bus.i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register; reset aborts any transaction in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            trap_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // outputs are qualified by state so everything idles at zero
    assign bus.o_req_ready = (state_q == IDLE);
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_mem_valid = st_issue;
    assign bus.o_mem_ren   = st_issue & ~we_q;
    assign bus.o_mem_wen   = st_issue & we_q;
    assign bus.o_mem_addr  = st_issue ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.o_mem_mask  = st_issue ? mask : 4'b0000;
    assign bus.o_mem_wdata = st_issue ? wdata_al : 32'b0;
    assign bus.o_rsp_valid = st_resp;
    assign bus.o_rsp_rdata = st_resp ? rdata_q : 32'b0;
    assign bus.o_rsp_trap  = st_resp & trap_q;
    assign bus.o_rsp_cause = st_resp ? cause_q : 2'b00;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (TIMEOUT=4) with a response scoreboard.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_ctrl_if #(.ADDR_W(32)) bus ();
    lsu_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [31:0] rdata;
        logic        trap;
        logic [1:0]  cause;
        int          due;
    } exp_t;
    exp_t q[$];
    exp_t cur;
    bit   have_cur = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // response monitor: pops at the first RESP cycle, re-checks while held
    always @(negedge clk) begin
        if (rst_n && bus.o_rsp_valid) begin
            if (!have_cur) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp at cycle %0d", cyc);
                end else begin
                    cur = q.pop_front();
                    have_cur = 1;
                    chk("rsp_cycle", cyc, cur.due);
                end
            end
            if (have_cur) begin
                chk("rsp_rdata", bus.o_rsp_rdata, cur.rdata);
                chk("rsp_trap_cause", {bus.o_rsp_trap, bus.o_rsp_cause}, {cur.trap, cur.cause});
                chk("rsp_req_ready", bus.o_req_ready, 1'b0);
            end
            if (bus.i_rsp_ready) have_cur = 0;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic push, input logic [31:0] erd,
                         input logic etrap, input logic [1:0] ecause, input int lat);
        exp_t e;
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = we;
        bus.i_req_funct3 = f3;
        bus.i_req_addr   = addr;
        bus.i_req_wdata  = wd;
        if (push) begin
            e.rdata = erd; e.trap = etrap; e.cause = ecause; e.due = cyc + lat;
            q.push_back(e);
        end
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
    endtask

    task automatic chk_mem(input string name, input logic ren, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] wd);
        @(negedge clk);
        chk(name, {bus.o_mem_valid, bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_mask, bus.o_mem_wdata},
            {1'b1, ren, ~ren, addr, mask, wd});
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_req_ready) begin ok = 1; break; end
        end
        chk("idle_wait", ok, 1'b1);
        @(posedge clk); #1;
    endtask

    // load with a junk rvalid in the handshake cycle, data one cycle later
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] mrd,
                           input logic [31:0] erd, input logic [3:0] emask);
        issue(1'b0, f3, addr, 32'h0, 1'b1, erd, 1'b0, 2'b00, 3);
        chk_mem("ld_mem", 1'b1, {addr[31:2], 2'b00}, emask, 32'h0);
        bus.i_mem_ready  = 1'b1;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rdata  = mrd;
        @(posedge clk); #1;
        bus.i_mem_rvalid = 1'b0;
        wait_idle();
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] ewd, input logic [3:0] emask, input int stall);
        issue(1'b1, f3, addr, wd, 1'b1, 32'h0, 1'b0, 2'b00, 2 + stall);
        for (int k = 0; k <= stall; k++) begin
            chk_mem("st_mem", 1'b0, {addr[31:2], 2'b00}, emask, ewd);
            if (k == stall) bus.i_mem_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.i_mem_ready = 1'b0;
        wait_idle();
    endtask

    task automatic do_trap(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [1:0] cause);
        issue(we, f3, addr, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, cause, 1);
        @(negedge clk);
        chk("trap_no_mem", {bus.o_mem_valid, bus.o_mem_ren, bus.o_mem_wen}, 3'b000);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req_valid = 0; bus.i_req_we = 0; bus.i_req_funct3 = 0; bus.i_req_addr = 0;
        bus.i_req_wdata = 0; bus.i_rsp_ready = 1; bus.i_mem_ready = 0;
        bus.i_mem_rvalid = 0; bus.i_mem_rdata = 0;
        #2;
        chk("rst_ready", bus.o_req_ready, 1'b1);
        chk("rst_outs", {bus.o_busy, bus.o_rsp_valid, bus.o_rsp_trap, bus.o_rsp_cause, bus.o_rsp_rdata,
            bus.o_mem_valid, bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_mask, bus.o_mem_addr, bus.o_mem_wdata}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;                      // request offered in the release cycle
        do_load(3'd0, 32'h1003, 32'h80FF_FF00, 32'hFFFF_FF80, 4'b1000);   // lb
        do_load(3'd4, 32'h1003, 32'h80FF_FF00, 32'h0000_0080, 4'b1000);   // lbu
        do_load(3'd1, 32'h1002, 32'h80FF_FF00, 32'hFFFF_80FF, 4'b1100);   // lh
        do_load(3'd5, 32'h1000, 32'h80FF_FF00, 32'h0000_FF00, 4'b0011);   // lhu
        do_load(3'd2, 32'h1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);   // lw
        // sh with 3 stall cycles; ready lands on the timeout cycle and wins
        do_store(3'd1, 32'h2002, 32'h1234_ABCD, 32'hABCD_0000, 4'b1100, 3);
        do_store(3'd0, 32'h2001, 32'h0000_00A5, 32'h0000_A500, 4'b0010, 0);
        do_store(3'd2, 32'h2004, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 0);
        do_trap(1'b0, 3'd2, 32'h3001, 2'b01);   // lw misaligned
        do_trap(1'b1, 3'd3, 32'h3000, 2'b11);   // store funct3=3
        do_trap(1'b0, 3'd1, 32'h3003, 2'b01);   // lh misaligned
        do_trap(1'b0, 3'd6, 32'h3001, 2'b11);   // illegal outranks misaligned

        // timeout while ISSUE never sees ready
        issue(1'b0, 3'd2, 32'h4000, 32'h0, 1'b1, 32'h0, 1'b1, 2'b10, 5);
        for (int k = 0; k < 4; k++) begin
            chk_mem("to_issue_mem", 1'b1, 32'h4000, 4'b1111, 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_mem_drop", bus.o_mem_valid, 1'b0);
        wait_idle();
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("late_rvalid_idle", {bus.o_busy, bus.o_req_ready}, 2'b01);
            @(posedge clk); #1;
        end
        bus.i_mem_rvalid = 1'b0;

        // timeout while WAIT never sees rvalid
        issue(1'b0, 3'd2, 32'h4008, 32'h0, 1'b1, 32'h0, 1'b1, 2'b10, 5);
        chk_mem("to_wait_mem", 1'b1, 32'h4008, 4'b1111, 32'h0);
        bus.i_mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_mem_ready = 1'b0;
        wait_idle();

        // response back-pressure: rsp_ready low for the first two RESP cycles
        bus.i_rsp_ready = 1'b0;
        issue(1'b0, 3'd0, 32'h1001, 32'h0, 1'b1, 32'h0000_007F, 1'b0, 2'b00, 3);
        chk_mem("bp_mem", 1'b1, 32'h1000, 4'b0010, 32'h0);
        bus.i_mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h0000_7F00;
        @(posedge clk); #1;
        bus.i_mem_rvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b1;
        wait_idle();

        // async reset pulse while a load sits in WAIT: aborted, no response
        issue(1'b0, 3'd2, 32'h5000, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 0);
        bus.i_mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", bus.o_req_ready, 1'b1);
        chk("midrst_outs", {bus.o_busy, bus.o_rsp_valid, bus.o_rsp_trap, bus.o_rsp_cause, bus.o_rsp_rdata,
            bus.o_mem_valid, bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_mask, bus.o_mem_addr, bus.o_mem_wdata}, '0);
        rst_n = 1'b1;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h1111_2222;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("midrst_idle", {bus.o_busy, bus.o_rsp_valid}, 2'b00);
            @(posedge clk); #1;
        end
        bus.i_mem_rvalid = 1'b0;

        do_load(3'd4, 32'h1002, 32'h00AB_0000, 32'h0000_00AB, 4'b0100);   // lbu after reset
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width; legal range 8..32.
REQ-002 Parameter TIMEOUT, default 255, max cycles spent in ISSUE+WAIT; 0 disables timeout.
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_req_valid  in  1, o_req_ready  out  1: the core request handshake.
REQ-006 i_req_we  in  1 (1=store), i_req_funct3  in  3 (RV32 load/store funct3), i_req_addr  in  ADDR_W, i_req_wdata  in  32.
REQ-007 o_rsp_valid  out  1, i_rsp_ready  in  1: the core response handshake.
REQ-008 o_rsp_rdata  out  32 (extended load data), o_rsp_trap  out  1, o_rsp_cause  out  2 (00 none, 01 misaligned, 10 timeout, 11 illegal funct3).
REQ-009 o_mem_valid  out  1, i_mem_ready  in  1: the memory request handshake.
REQ-010 o_mem_addr  out  ADDR_W (word-aligned, bits[1:0]=0), o_mem_ren  out  1, o_mem_wen  out  1, o_mem_wdata  out  32, o_mem_mask  out  4.
REQ-011 i_mem_rvalid  in  1, i_mem_rdata  in  32: read data return.
REQ-012 o_busy  out  1: asserted whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; o_req_ready=1 only in IDLE.
REQ-014 On accept (valid&ready), the block SHALL register we, funct3, addr and wdata, then check legality in this priority: illegal funct3 (load 3/6/7, store >=3), then misalignment (half offset[0]=1, word offset!=0).
REQ-015 An illegal request SHALL go IDLE->RESP with trap=1, its cause, rdata=0, and no memory access.
REQ-016 A legal request SHALL go IDLE->ISSUE; in ISSUE o_mem_valid=1, ren=~we, wen=we, and addr/mask/wdata SHALL stay stable until i_mem_ready.
REQ-017 The mask SHALL be: byte 0001<<off; half 0011<<off; word 1111.
REQ-018 Store wdata SHALL be the low byte or half shifted left by 8*off; a word store passes unchanged.
REQ-019 ISSUE with i_mem_ready: a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-020 In WAIT, i_mem_rvalid SHALL capture i_mem_rdata and move to RESP.
REQ-021 i_mem_rvalid SHALL be ignored in all states other than WAIT, including the handshake cycle.
REQ-022 The captured data SHALL be shifted right by 8*off and then sign-extended (lb/lh) or zero-extended (lbu/lhu); lw passes unchanged.
REQ-023 A cycle counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE or WAIT.
REQ-024 If TIMEOUT!=0 and the counter reaches TIMEOUT before completion, the block SHALL go to RESP with trap=1, cause=10, rdata=0, and drop o_mem_valid.
REQ-025 Completion and timeout in the same cycle SHALL resolve as completion.
REQ-026 In RESP, o_rsp_valid=1 with data/trap/cause held stable until i_rsp_ready; then the block SHALL return to IDLE.
REQ-027 o_rsp_valid SHALL be 0 outside RESP, and o_mem_valid/ren/wen SHALL be 0 outside ISSUE.
REQ-028 Minimum latency from accept cycle 0: trap response at cycle 1, store response at cycle 2 (ready at cycle 1), load response at cycle 3 (ready at 1, rvalid at 2).
REQ-029 Only one request SHALL be outstanding; there is no request pipelining.

Reset
REQ-030 Asserting i_rst_n=0 SHALL immediately force IDLE, clear the counter, and set every output to 0 except o_req_ready=1, regardless of the current state.
REQ-031 A reset mid-transaction SHALL abort it with no response; a later i_mem_rvalid SHALL be ignored.
REQ-032 After release, the first edge with i_rst_n=1 SHALL already accept a request.

Verification
REQ-033 lb at 0x1003, mem returns 0x80FF_FF00 -> mask 1000, addr 0x1000, rsp rdata 0xFFFF_FF80, trap 0; with lbu -> 0x0000_0080.
REQ-034 sh at 0x2002, wdata 0x1234_ABCD, i_mem_ready held low 3 cycles -> wdata 0xABCD_0000, mask 1100, signals stable across the stall, rsp at cycle 5.
REQ-035 lw at 0x3001 -> rsp at cycle 1, trap 1, cause 01, o_mem_valid never asserted; store funct3=3 -> cause 11.
REQ-036 TIMEOUT=4, load with i_mem_ready never asserted -> rsp at cycle 5 with cause 10; a later rvalid is ignored and IDLE is kept.
REQ-037 Load in WAIT, i_rst_n pulsed low asynchronously mid-cycle -> outputs 0 immediately, o_req_ready=1, no rsp.
REQ-038 i_rsp_ready low 2 cycles in RESP -> rsp fields stable and o_req_ready=0 until the handshake completes.
